mono_rx_stream_arbiter: RTL
===========================

Name: mono_rx_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that merges the output FIFOs of N pixel-receiver cores into one downstream FIFO/SiTCP stream.
- Sits between the per-chip receiver output FIFOs (32-bit words; bits [31:30] carry the source identifier, bits [29:28] carry the word tag) and the shared readout FIFO.
- Forwards each hit packet of PKT_WORDS words contiguously, so packets from different receivers never interleave.
- Detects misaligned and stalled packets and counts them.

Parameters:
- N_SRC, 4, number of receiver sources (1..8).
- PKT_WORDS, 3, words per hit packet (2..15).
- SOP_TAG, 2'b01, required value of bits [29:28] on the first word of a packet.
- TIMEOUT, 255, cycles a granted source may stay empty mid-packet before the packet is aborted (1..65535).

Ports:
- BUS_CLK  in  1  clock.
- RST  in  1  reset.
- EN_MASK  in  N_SRC  per-source enable; a masked source is never granted.
- SRC_EMPTY  in  N_SRC  per-source FIFO empty.
- SRC_DATA  in  32*N_SRC  per-source first-word-fall-through data; source i occupies [32i+31:32i].
- SRC_READ  out  N_SRC  per-source pop strobe (combinational).
- OUT_FULL  in  1  downstream almost-full; must assert with at least one free entry remaining.
- OUT_WRITE  out  1  downstream write strobe (registered).
- OUT_DATA  out  32  downstream write data (registered).
- BUSY  out  1  high while a packet is granted.
- GRANT_ID  out  3  index of the current or last granted source.
- DROP_CNT  out  8  count of words discarded for a missing SOP; saturates at 255.
- ABORT_CNT  out  8  count of packets aborted by timeout; saturates at 255.

Behaviour:
- Reset is RST, synchronous, active-high, on clock BUS_CLK.
- Reset values:
  - state = IDLE; SRC_READ = 0; OUT_WRITE = 0; OUT_DATA = 0; BUSY = 0.
  - GRANT_ID = N_SRC-1, so source 0 is searched first.
  - DROP_CNT = 0; ABORT_CNT = 0; word counter = 0; timeout counter = 0.
- States: IDLE, XFER.
- IDLE:
  - req = ~SRC_EMPTY & EN_MASK.
  - Pick the first set req bit strictly after GRANT_ID, wrapping modulo N_SRC.
  - If the picked source's head word has [29:28] != SOP_TAG: pop it without writing (SRC_READ[i] = 1 for one cycle), increment DROP_CNT, set GRANT_ID = i, stay in IDLE. The pop happens regardless of OUT_FULL.
  - If the head word carries SOP_TAG: set GRANT_ID = i, go to XFER, word counter = 0, BUSY = 1. The word is not consumed in this cycle.
  - At most one grant decision per cycle.
- XFER, for granted source g:
  - SRC_READ[g] = ~SRC_EMPTY[g] & ~OUT_FULL; all other SRC_READ bits are 0.
  - On a pop: the next cycle gives OUT_WRITE = 1 and OUT_DATA = popped word (one-cycle latency).
  - On a pop: word counter increments and the timeout counter clears.
  - When the pop is the PKT_WORDS-th word: go to IDLE the next cycle, BUSY = 0. GRANT_ID keeps g, so the next search starts at g+1.
  - Tags of non-first words are not checked; words are passed through unmodified.
  - Timeout counter increments only while SRC_EMPTY[g] = 1. OUT_FULL stalls do not count toward timeout.
  - When the timeout counter reaches TIMEOUT: go to IDLE, increment ABORT_CNT, BUSY = 0. Words already forwarded stay forwarded; the remainder of that packet is treated as orphan words (dropped in IDLE, since their tag is not SOP).
- EN_MASK:
  - Clearing EN_MASK[g] mid-packet does not abort; the packet completes or times out.
  - A masked source's head is not dropped.
- Simultaneous events:
  - With every source requesting continuously, grant order is strictly 0,1,...,N_SRC-1,0,...
  - Each counter saturates independently.
  - A pop on the exact cycle the timeout counter would reach TIMEOUT wins: no abort.
- Throughput: one word per cycle inside a packet; one idle grant cycle between packets.
- RST mid-packet: all outputs return to reset values on the next edge; the partial packet is not completed.
- Invalid parameter values (out of the stated ranges) are not supported.

Test Plan:
1. Single packet: N_SRC=4; src2 holds 3 words (tag 01, then 10, then 11), others empty.
   - Required: GRANT_ID=2; OUT_WRITE high for 3 consecutive cycles with data in order; BUSY low afterwards; DROP_CNT=0.
2. Fairness: all 4 sources preloaded with 2 packets each, OUT_FULL=0.
   - Required: 24 output words; source IDs (bits [31:30]) follow 0,1,2,3,0,1,2,3 per packet, each packet contiguous; no gap inside a packet, one-cycle gap between packets.
3. Backpressure: during a src1 packet, OUT_FULL is high for 5 cycles after word 1.
   - Required: no SRC_READ while OUT_FULL is high; word 2 written after release; no abort; ABORT_CNT=0.
4. Misalignment: src0 head = tag 10 word followed by a valid packet.
   - Required: orphan word dropped (no OUT_WRITE), DROP_CNT=1, then the valid packet forwarded intact.
5. Timeout: TIMEOUT=10; src3 gives 1 word, then stays empty 10 cycles, then delivers its last 2 words.
   - Required: ABORT_CNT=1; BUSY falls on cycle 10 of the stall; the late 2 words are dropped; DROP_CNT=2.
6. Mask and reset: EN_MASK=4'b1011 with all sources full.
   - Required: src2 never granted.
   - Then RST asserted mid-packet: next cycle OUT_WRITE=0, BUSY=0, counters 0, GRANT_ID=3, and the first grant after reset goes to src0.

Source files
------------

// File: rtl/mono_rx_stream_arbiter.sv
// Packet-aware round-robin merger of N receiver output FIFOs into one readout stream.
// Whole packets go out contiguously; orphan words are dropped and stalled packets aborted.
module mono_rx_stream_arbiter #(
  parameter int         N_SRC     = 4,
  parameter int         PKT_WORDS = 3,
  parameter logic [1:0] SOP_TAG   = 2'b01,
  parameter int         TIMEOUT   = 255
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [N_SRC-1:0]     EN_MASK,
  input  logic [N_SRC-1:0]     SRC_EMPTY,
  input  logic [32*N_SRC-1:0]  SRC_DATA,
  output logic [N_SRC-1:0]     SRC_READ,
  input  logic                 OUT_FULL,
  output logic                 OUT_WRITE,
  output logic [31:0]          OUT_DATA,
  output logic                 BUSY,
  output logic [2:0]           GRANT_ID,
  output logic [7:0]           DROP_CNT,
  output logic [7:0]           ABORT_CNT
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam logic [2:0]  GRANT_RST    = 3'(N_SRC - 1);
  localparam logic [3:0]  LAST_WORD    = 4'(PKT_WORDS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  // Lowest requesting index strictly above 'last', else lowest index at or below it.
  function automatic logic [3:0] rr_pick(input logic [N_SRC-1:0] req, input logic [2:0] last);
    logic       hi_v;
    logic       lo_v;
    logic [2:0] hi_i;
    logic [2:0] lo_i;
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi_i = 3'd0;
    lo_i = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) > last)) begin
        hi_v = 1'b1;
        hi_i = 3'(i);
      end else if (req[i]) begin
        lo_v = 1'b1;
        lo_i = 3'(i);
      end else begin
        hi_v = hi_v;
      end
    end
    if (hi_v) begin
      return {1'b1, hi_i};
    end else if (lo_v) begin
      return {1'b1, lo_i};
    end else begin
      return 4'b0000;
    end
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [2:0] idx);
    logic [N_SRC-1:0] o;
    for (int i = 0; i < N_SRC; i++) begin
      o[i] = (idx == 3'(i));
    end
    return o;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [7:0]        drop_q, drop_d;
  logic [7:0]        abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              out_write_q, out_write_d;
  logic [31:0]       out_data_q, out_data_d;

  logic [31:0]       src_word_s [N_SRC];
  logic [N_SRC-1:0]  req_s;
  logic [3:0]        pick_s;
  logic              pick_vld_s;
  logic [2:0]        pick_idx_s;
  logic [1:0]        pick_tag_s;
  logic              g_empty_s;
  logic [31:0]       g_data_s;
  logic              g_pop_s;
  logic [N_SRC-1:0]  read_s;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_word_s[i] = SRC_DATA[32*i +: 32];
    end
  end

  assign req_s      = ~SRC_EMPTY & EN_MASK;
  assign pick_s     = rr_pick(req_s, grant_q);
  assign pick_vld_s = pick_s[3];
  assign pick_idx_s = pick_s[2:0];

  // Head tag of the candidate source and status/data of the granted source.
  always_comb begin
    pick_tag_s = 2'b00;
    g_empty_s  = 1'b1;
    g_data_s   = 32'h0000_0000;
    for (int i = 0; i < N_SRC; i++) begin
      pick_tag_s = (pick_idx_s == 3'(i)) ? src_word_s[i][29:28] : pick_tag_s;
      g_empty_s  = (grant_q == 3'(i)) ? SRC_EMPTY[i] : g_empty_s;
      g_data_s   = (grant_q == 3'(i)) ? src_word_s[i] : g_data_s;
    end
  end

  assign g_pop_s = ~g_empty_s & ~OUT_FULL;

  // Grant decision, packet transfer and timeout handling.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    drop_d      = drop_q;
    abort_d     = abort_q;
    busy_d      = busy_q;
    out_write_d = 1'b0;
    out_data_d  = out_data_q;
    read_s      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s && (pick_tag_s != SOP_TAG)) begin
          // Orphan head: discard it even under backpressure so it cannot block the source.
          grant_d = pick_idx_s;
          read_s  = onehot(pick_idx_s);
          drop_d  = sat_inc(drop_q);
        end else if (pick_vld_s) begin
          grant_d = pick_idx_s;
          state_d = ST_XFER;
          busy_d  = 1'b1;
          wcnt_d  = 4'd0;
          tcnt_d  = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (g_pop_s) begin
          read_s      = onehot(grant_q);
          out_write_d = 1'b1;
          out_data_d  = g_data_s;
          tcnt_d      = 16'd0;
          if (wcnt_q == LAST_WORD) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            wcnt_d  = 4'd0;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end else if (g_empty_s) begin
          if (tcnt_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            abort_d = sat_inc(abort_q);
            tcnt_d  = 16'd0;
            wcnt_d  = 4'd0;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // No FIFO is popped while reset is held.
  assign SRC_READ = RST ? '0 : read_s;

  // State and output registers with synchronous reset.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_RST;
      wcnt_q      <= 4'd0;
      tcnt_q      <= 16'd0;
      drop_q      <= 8'd0;
      abort_q     <= 8'd0;
      busy_q      <= 1'b0;
      out_write_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      drop_q      <= drop_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      out_write_q <= out_write_d;
      out_data_q  <= out_data_d;
    end
  end

  assign OUT_WRITE = out_write_q;
  assign OUT_DATA  = out_data_q;
  assign BUSY      = busy_q;
  assign GRANT_ID  = grant_q;
  assign DROP_CNT  = drop_q;
  assign ABORT_CNT = abort_q;

endmodule
